branch_resolve_unit: RTL and testbench

//  Execute-stage branch/jump resolver downstream of the 32-bit comparator.
//  - Drives the comparator's signed-select; consumes its gt/lt/eq flags.
//  - Decides taken/not-taken and computes the target and link (pc+4).
//  - Registers the result into a one-entry valid/ready output slot, pulses a

---
 rtl/branch_resolve_unit.sv | 148 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver: evaluates the branch condition from the comparator
// flags, computes the target and link, and holds the result in a one-entry valid/ready slot.
// A taken, aligned result also sends a one-cycle fetch redirect and discards the next
// SQUASH_CNT accepted instructions, which are the wrong-path ones.
module branch_resolve_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SQUASH_CNT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_branch,
  input  logic            in_is_jal,
  input  logic            in_is_jalr,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1,
  output logic            cmp_is_signed,
  input  logic            cmp_gt,
  input  logic            cmp_lt,
  input  logic            cmp_eq,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_misalign,
  output logic            out_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned CW = 3;

  logic            out_valid_q, out_valid_d;
  logic            out_taken_q, out_taken_d;
  logic [XLEN-1:0] out_target_q, out_target_d;
  logic [XLEN-1:0] out_link_q, out_link_d;
  logic            out_misalign_q, out_misalign_d;
  logic            out_illegal_q, out_illegal_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [CW-1:0]   squash_cnt_q, squash_cnt_d;

  logic            accept, squashing, cond;
  logic            taken_c, misalign_c, illegal_c;
  logic [XLEN-1:0] target_c, br_target, jalr_sum;

  assign in_ready      = !out_valid_q || out_ready;
  assign cmp_is_signed = (in_funct3[2:1] == 2'b10);
  assign accept        = in_valid && in_ready;
  assign squashing     = (squash_cnt_q != '0);
  assign br_target     = in_pc + in_imm;
  assign jalr_sum      = in_rs1 + in_imm;

  // Resolve condition, target and exception flags for the presented instruction
  always_comb begin
    cond      = 1'b0;
    illegal_c = 1'b0;
    taken_c   = 1'b0;
    target_c  = '0;
    unique case (in_funct3)
      3'b000:         cond = cmp_eq;
      3'b001:         cond = !cmp_eq;
      3'b100, 3'b110: cond = cmp_lt;
      3'b101, 3'b111: cond = cmp_gt || cmp_eq;
      default:        cond = 1'b0;
    endcase
    if (in_is_branch) begin
      taken_c   = cond;
      target_c  = br_target;
      illegal_c = (in_funct3[2:1] == 2'b01);
    end else if (in_is_jal) begin
      taken_c  = 1'b1;
      target_c = br_target;
    end else if (in_is_jalr) begin
      taken_c  = 1'b1;
      target_c = jalr_sum & ~XLEN'(1);
    end
    misalign_c = taken_c && (target_c[1:0] != 2'b00);
  end

  // Slot, redirect pulse and squash counter next state
  always_comb begin
    out_valid_d      = out_valid_q && !out_ready;
    out_taken_d      = out_taken_q;
    out_target_d     = out_target_q;
    out_link_d       = out_link_q;
    out_misalign_d   = out_misalign_q;
    out_illegal_d    = out_illegal_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    squash_cnt_d     = squash_cnt_q;
    if (accept) begin
      if (squashing) begin
        squash_cnt_d = squash_cnt_q - CW'(1);
      end else begin
        out_valid_d    = 1'b1;
        out_taken_d    = taken_c;
        out_target_d   = target_c;
        out_link_d     = in_pc + XLEN'(4);
        out_misalign_d = misalign_c;
        out_illegal_d  = illegal_c;
        if (taken_c && !misalign_c) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target_c;
          squash_cnt_d     = CW'(SQUASH_CNT);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_target_q     <= '0;
      out_link_q       <= '0;
      out_misalign_q   <= 1'b0;
      out_illegal_q    <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      squash_cnt_q     <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_taken_q      <= out_taken_d;
      out_target_q     <= out_target_d;
      out_link_q       <= out_link_d;
      out_misalign_q   <= out_misalign_d;
      out_illegal_q    <= out_illegal_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      squash_cnt_q     <= squash_cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_taken      = out_taken_q;
  assign out_target     = out_target_q;
  assign out_link       = out_link_q;
  assign out_misalign   = out_misalign_q;
  assign out_illegal    = out_illegal_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed cases from the branch-resolution rules followed by a
// randomized run, all compared against a transaction-level reference model.
module tb_branch_resolve_unit;

  localparam int unsigned XLEN = 32;
  localparam int          SQ   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic            in_is_branch, in_is_jal, in_is_jalr;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_pc, in_imm, in_rs1;
  logic            cmp_is_signed, cmp_gt, cmp_lt, cmp_eq;
  logic            out_valid, out_ready, out_taken, out_misalign, out_illegal;
  logic [XLEN-1:0] out_target, out_link;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  branch_resolve_unit #(.XLEN(XLEN), .SQUASH_CNT(SQ)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_branch(in_is_branch), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
    .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1),
    .cmp_is_signed(cmp_is_signed), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_link(out_link), .out_misalign(out_misalign),
    .out_illegal(out_illegal), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: the contents of the result slot and the redirect/squash bookkeeping
  bit              m_valid, m_taken, m_mis, m_ill, m_rv;
  bit [XLEN-1:0]   m_target, m_link, m_rpc;
  int              m_squash_left;

  localparam int K_NONE = 0, K_BR = 1, K_JAL = 2, K_JALR = 3;

  // One clock cycle: present inputs (operands a/b feed a modelled comparator), predict, check
  task automatic step(input bit v, input int kind, input bit [2:0] f3,
                      input bit [XLEN-1:0] pc, input bit [XLEN-1:0] imm, input bit [XLEN-1:0] rs1,
                      input bit [XLEN-1:0] a, input bit [XLEN-1:0] b,
                      input bit ordy, input bit r);
    bit sgn, lt, eq, cond, taken, mis, ill, acc, was_rst;
    bit [XLEN-1:0] tgt;
    rst = r; in_valid = v; out_ready = ordy;
    in_is_branch = (kind == K_BR); in_is_jal = (kind == K_JAL); in_is_jalr = (kind == K_JALR);
    in_funct3 = f3; in_pc = pc; in_imm = imm; in_rs1 = rs1;
    sgn = (f3 == 3'd4) || (f3 == 3'd5);
    lt  = sgn ? ($signed(a) < $signed(b)) : (a < b);
    eq  = (a == b);
    cmp_lt = lt; cmp_eq = eq; cmp_gt = !lt && !eq;
    #1;
    check("in_ready", XLEN'(in_ready), XLEN'(!m_valid || ordy));
    check("cmp_is_signed", XLEN'(cmp_is_signed), XLEN'(sgn));

    // Architectural resolution of the presented instruction
    cond = 0; ill = 0; taken = 0; tgt = '0;
    case (f3)
      3'd0: cond = eq;
      3'd1: cond = !eq;
      3'd4, 3'd6: cond = lt;
      3'd5, 3'd7: cond = !lt;
      default: cond = 0;
    endcase
    case (kind)
      K_BR:   begin taken = cond; tgt = pc + imm; ill = (f3 == 3'd2) || (f3 == 3'd3); end
      K_JAL:  begin taken = 1; tgt = pc + imm; end
      K_JALR: begin taken = 1; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
      default: ;
    endcase
    mis = taken && (tgt % 4 != 0);
    acc = v && (!m_valid || ordy);

    @(posedge clk);
    #1;
    was_rst = r;
    if (r) begin
      m_valid = 0; m_taken = 0; m_mis = 0; m_ill = 0; m_rv = 0;
      m_target = '0; m_link = '0; m_rpc = '0; m_squash_left = 0;
    end else begin
      if (m_valid && ordy) m_valid = 0;
      m_rv = 0;
      if (acc) begin
        if (m_squash_left > 0) begin
          m_squash_left--;
        end else begin
          m_valid = 1; m_taken = taken; m_target = tgt; m_link = pc + 4;
          m_mis = mis; m_ill = ill;
          if (taken && !mis) begin
            m_rv = 1; m_rpc = tgt; m_squash_left = SQ;
          end
        end
      end
    end

    check("out_valid", XLEN'(out_valid), XLEN'(m_valid));
    check("redirect_valid", XLEN'(redirect_valid), XLEN'(m_rv));
    if (m_valid || was_rst) begin
      check("out_taken", XLEN'(out_taken), XLEN'(m_taken));
      check("out_target", out_target, m_target);
      check("out_link", out_link, m_link);
      check("out_misalign", XLEN'(out_misalign), XLEN'(m_mis));
      check("out_illegal", XLEN'(out_illegal), XLEN'(m_ill));
    end
    if (m_rv || was_rst) check("redirect_pc", redirect_pc, m_rpc);
  endtask

  task automatic idle(input bit ordy);
    step(0, K_NONE, 3'd0, '0, '0, '0, '0, '0, ordy, 0);
  endtask

  task automatic pass_thru(input bit [XLEN-1:0] pc);
    step(1, K_NONE, 3'd0, pc, '0, '0, '0, '0, 1, 0);
  endtask

  // Discards the wrong-path window following a redirect
  task automatic flush();
    pass_thru(32'h0); pass_thru(32'h0);
  endtask

  initial begin
    step(0, K_NONE, 3'd0, '0, '0, '0, '0, '0, 1, 1);
    step(0, K_NONE, 3'd0, '0, '0, '0, '0, '0, 1, 1);
    check("reset out_valid", XLEN'(out_valid), '0);
    check("reset redirect", XLEN'(redirect_valid), '0);

    // BEQ taken: redirect, two discards, third instruction appears
    step(1, K_BR, 3'd0, 32'h100, 32'h20, '0, 32'd5, 32'd5, 1, 0);
    check("beq taken", XLEN'(out_taken), 32'd1);
    check("beq target", out_target, 32'h120);
    check("beq link", out_link, 32'h104);
    check("beq redirect", XLEN'(redirect_valid), 32'd1);
    idle(1);
    check("beq redirect once", XLEN'(redirect_valid), 32'd0);
    pass_thru(32'h200);
    check("squash 1", XLEN'(out_valid), 32'd0);
    pass_thru(32'h204);
    check("squash 2", XLEN'(out_valid), 32'd0);
    pass_thru(32'h208);
    check("post squash valid", XLEN'(out_valid), 32'd1);
    check("post squash link", out_link, 32'h20C);

    // BLTU vs BLT on the same operands
    step(1, K_BR, 3'b110, 32'h300, 32'h40, '0, 32'h8000_0000, 32'd1, 1, 0);
    check("bltu not taken", XLEN'(out_taken), 32'd0);
    step(1, K_BR, 3'b100, 32'h300, 32'h40, '0, 32'h8000_0000, 32'd1, 1, 0);
    check("blt taken", XLEN'(out_taken), 32'd1);
    flush();

    // JALR misaligned then aligned
    step(1, K_JALR, 3'd0, 32'h400, 32'h2, 32'h1001, '0, '0, 1, 0);
    check("jalr mis target", out_target, 32'h1002);
    check("jalr misalign", XLEN'(out_misalign), 32'd1);
    check("jalr mis no redirect", XLEN'(redirect_valid), 32'd0);
    step(1, K_JALR, 3'd0, 32'h404, 32'h0, 32'h1001, '0, '0, 1, 0);
    check("jalr unsquashed", XLEN'(out_valid), 32'd1);
    check("jalr target", out_target, 32'h1000);
    check("jalr redirect", XLEN'(redirect_valid), 32'd1);
    flush();

    // JAL wrap-around
    step(1, K_JAL, 3'd0, 32'hFFFF_FFFC, 32'd8, '0, '0, '0, 1, 0);
    check("jal wrap target", out_target, 32'h4);
    check("jal wrap link", out_link, 32'h0);
    flush();

    // BNE taken with a stalled slot
    step(1, K_BR, 3'd1, 32'h500, 32'h80, '0, 32'd1, 32'd2, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, K_NONE, 3'd0, 32'h600, '0, '0, '0, '0, 0, 0);
      check("stall target", out_target, 32'h580);
    end
    for (int i = 0; i < 4; i++) pass_thru(32'h700 + 4 * i);

    // Illegal funct3
    step(1, K_BR, 3'b010, 32'h800, 32'h10, '0, 32'd3, 32'd3, 1, 0);
    check("illegal flag", XLEN'(out_illegal), 32'd1);
    check("illegal not taken", XLEN'(out_taken), 32'd0);

    // Reset in the middle of a squash window
    step(1, K_JAL, 3'd0, 32'h900, 32'h40, '0, '0, '0, 1, 0);
    pass_thru(32'h904);
    step(0, K_NONE, 3'd0, '0, '0, '0, '0, '0, 1, 1);
    pass_thru(32'h908);
    check("after rst unsquashed", XLEN'(out_valid), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit [XLEN-1:0] a, b, pc, imm, rs1;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc  = $urandom & 32'hFFFF_FFFC;
      imm = ($urandom_range(0, 3) == 0) ? 32'($urandom) : ($urandom & 32'hFFFF_FFFC);
      rs1 = $urandom;
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           pc, imm, rs1, a, b, $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
